vx_inter_agent: RTL and testbench
=================================

# vx_inter_agent

Initiator-side agent for the per-core interpolation unit. It accepts one warp instruction from dispatch, carrying per-lane x/y operands and writeback metadata. It serialises one interpolation request per active lane onto the interpolator request channel and gathers each scalar response into a per-lane result buffer. When all active lanes are done, it presents a single commit packet to writeback. It sits in the execute stage between dispatch and the interpolator; the interpolator's a/b/c CSRs are programmed separately and are not touched here.

## Interface
- CORE_ID, 0, core index (informational only)
- NUM_THREADS, 4, lanes per warp
- NW_WIDTH, 2, warp-id width
- UUID_WIDTH, 44, instruction uuid width
- NR_WIDTH, 5, destination register index width
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- disp_valid  in  1  dispatch packet valid
- disp_ready  out  1  agent can accept a packet
- disp_uuid / disp_wid / disp_tmask / disp_PC / disp_rd / disp_wb  in  UUID_WIDTH / NW_WIDTH / NUM_THREADS / 32 / NR_WIDTH / 1  instruction metadata
- disp_x, disp_y  in  NUM_THREADS*32 each  per-lane operands; lane i occupies bits [32i+31:32i]
- req_valid  out  1  interpolator request valid
- req_ready  in  1  interpolator accepts request
- req_x, req_y  out  32 each  operands of the current lane
- req_uuid  out  UUID_WIDTH  uuid of the held instruction
- rsp_valid  in  1  interpolator result valid
- rsp_data  in  32  result a*x + b*y + c (mod 2^32)
- rsp_ready  out  1  agent accepts result
- commit_valid  out  1  writeback packet valid
- commit_ready  in  1  writeback accepts the packet
- commit_uuid / commit_wid / commit_tmask / commit_PC / commit_rd / commit_wb  out  same widths as disp_*  held metadata
- commit_data  out  NUM_THREADS*32  per-lane results

## Operation
- FSM states: IDLE, ISSUE, WAIT, COMMIT.
- IDLE:
  - disp_ready=1.
  - On disp_valid, capture metadata, x and y into the held registers and clear the result buffer.
  - Load the pending mask with disp_tmask.
  - If the mask is nonzero, go to ISSUE with lane = lowest set bit; if the mask is zero, go to COMMIT.
- ISSUE:
  - req_valid=1; req_x, req_y and req_uuid come from the current lane's held registers.
  - When req_valid and req_ready are both high, go to WAIT.
  - Outputs stay stable while req_ready is low.
- WAIT:
  - rsp_ready=1.
  - On rsp_valid, write rsp_data into the current lane's result slot and clear that lane's bit in the pending mask.
  - Go to ISSUE with the next lowest pending lane, or to COMMIT if none remain.
- COMMIT:
  - commit_valid=1 with all commit_* outputs driven from held registers.
  - When commit_valid and commit_ready are both high, go to IDLE.
- Exactly one request is outstanding at a time; lanes are issued in ascending index order.
- Inactive lanes return 0 in commit_data.
- rsp_valid outside WAIT is ignored: rsp_ready=0 and no state change.
- Arithmetic is entirely in the interpolator; this block is pure data movement with no width changes.

## Timing
- Reset values: disp_ready=0 during reset and 1 from the first cycle after it; req_valid=0; rsp_ready=0; commit_valid=0; all data and metadata outputs 0; state=IDLE; pending mask=0.
- Reset mid-operation discards the held instruction; no commit is produced.
- Dispatch accepted in cycle T gives req_valid at T+1.
- With req_ready=1 and a same-cycle response, each active lane costs 2 cycles. For K active lanes, commit_valid rises at T+1+2K.
- An empty tmask gives commit_valid at T+1.
- disp_ready=0 outside IDLE, so there is no overlap between consecutive instructions. The next packet can be accepted in the cycle after the commit handshake.
- All outputs are registered or decoded from the state register only. There is no combinational path from input to output.

## Structure
- Shared package vx_inter_pkg holds:
  - the state enum inter_agent_state_t (IDLE, ISSUE, WAIT, COMMIT);
  - the localparam LANE_BITS = $clog2(NUM_THREADS), with a minimum of 1;
  - a request/commit metadata struct.
- Sub-module vx_inter_lane_sel: combinational lowest-set-bit finder. It takes the pending mask and returns the lane index plus a found flag, and is used both at dispatch and after each response.

## Test plan
- Model interpolator with a=2, b=3, c=1 and zero latency. tmask=4'b1111, x={1,2,3,4}, y={0,1,2,3} → commit_data={3,8,13,18}, and commit_valid at T+9.
- tmask=4'b1010 with the same operands → requests only for lanes 1 and 3; commit_data={0,8,0,18}; commit_tmask=4'b1010.
- tmask=4'b0000 → no req_valid; commit_valid at T+1 with all data 0.
- req_ready held low 5 cycles, then rsp delayed 3 cycles; commit_ready low 4 cycles → req_x/req_y stable throughout; spurious rsp_valid pulses in ISSUE/COMMIT are ignored; commit outputs are held stable.
- reset asserted while in WAIT on lane 2 → next cycle all outputs are at reset values; a fresh dispatch then completes correctly.
- Back-to-back dispatch with disp_valid held high → second packet is accepted only in the cycle after the first commit handshake; uuids are committed in order.

Source files
------------

// File: rtl/vx_inter_pkg.sv
// Shared types and constants for the interpolation-unit initiator agent.
package vx_inter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } inter_agent_state_t;

  localparam int NUM_THREADS_DEF = 4;
  localparam int UUID_WIDTH_DEF  = 44;
  localparam int NW_WIDTH_DEF    = 2;
  localparam int NR_WIDTH_DEF    = 5;

  // Lane index width; a single-lane warp still needs a 1-bit index.
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_BITS = lane_bits(NUM_THREADS_DEF);

  typedef struct packed {
    logic [UUID_WIDTH_DEF-1:0]  uuid;
    logic [NW_WIDTH_DEF-1:0]    wid;
    logic [NUM_THREADS_DEF-1:0] tmask;
    logic [31:0]                pc;
    logic [NR_WIDTH_DEF-1:0]    rd;
    logic                       wb;
  } inter_meta_t;

endpackage

// File: rtl/vx_inter_lane_sel.sv
// Lowest-set-bit finder over the pending lane mask.
module vx_inter_lane_sel #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  mask,
  output logic [LW-1:0] lane,
  output logic          found
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    lane  = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lane  = LW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_inter_agent.sv
// Interpolation agent: serialises one request per active lane, gathers the
// scalar results and commits the whole warp as one writeback packet.
module vx_inter_agent
  import vx_inter_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int NUM_THREADS = 4,
  parameter int NW_WIDTH    = 2,
  parameter int UUID_WIDTH  = 44,
  parameter int NR_WIDTH    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [UUID_WIDTH-1:0]     disp_uuid,
  input  logic [NW_WIDTH-1:0]       disp_wid,
  input  logic [NUM_THREADS-1:0]    disp_tmask,
  input  logic [31:0]               disp_PC,
  input  logic [NR_WIDTH-1:0]       disp_rd,
  input  logic                      disp_wb,
  input  logic [NUM_THREADS*32-1:0] disp_x,
  input  logic [NUM_THREADS*32-1:0] disp_y,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [31:0]               req_x,
  output logic [31:0]               req_y,
  output logic [UUID_WIDTH-1:0]     req_uuid,
  input  logic                      rsp_valid,
  input  logic [31:0]               rsp_data,
  output logic                      rsp_ready,
  output logic                      commit_valid,
  input  logic                      commit_ready,
  output logic [UUID_WIDTH-1:0]     commit_uuid,
  output logic [NW_WIDTH-1:0]       commit_wid,
  output logic [NUM_THREADS-1:0]    commit_tmask,
  output logic [31:0]               commit_PC,
  output logic [NR_WIDTH-1:0]       commit_rd,
  output logic                      commit_wb,
  output logic [NUM_THREADS*32-1:0] commit_data
);

  localparam int LANE_W = lane_bits(NUM_THREADS);

  inter_agent_state_t state_reg;

  logic                   disp_ready_reg;
  logic                   req_valid_reg;
  logic                   rsp_ready_reg;
  logic                   commit_valid_reg;
  logic [31:0]            req_x_reg;
  logic [31:0]            req_y_reg;
  logic [UUID_WIDTH-1:0]  req_uuid_reg;

  logic [UUID_WIDTH-1:0]  uuid_reg;
  logic [NW_WIDTH-1:0]    wid_reg;
  logic [NUM_THREADS-1:0] tmask_reg;
  logic [31:0]            pc_reg;
  logic [NR_WIDTH-1:0]    rd_reg;
  logic                   wb_reg;

  logic [NUM_THREADS-1:0] pending_reg;
  logic [LANE_W-1:0]      lane_reg;
  logic [31:0]            x_reg   [NUM_THREADS];
  logic [31:0]            y_reg   [NUM_THREADS];
  logic [31:0]            res_reg [NUM_THREADS];

  logic [31:0]            disp_x_lane [NUM_THREADS];
  logic [31:0]            disp_y_lane [NUM_THREADS];

  logic [LANE_W-1:0]      disp_lane;
  logic                   disp_found;
  logic [LANE_W-1:0]      next_lane;
  logic                   next_found;
  logic [NUM_THREADS-1:0] lane_onehot;
  logic [NUM_THREADS-1:0] pending_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
      assign disp_x_lane[gi]          = disp_x[gi*32 +: 32];
      assign disp_y_lane[gi]          = disp_y[gi*32 +: 32];
      assign commit_data[gi*32 +: 32] = res_reg[gi];
    end
  endgenerate

  // Mask left after the current lane's response retires.
  assign lane_onehot  = NUM_THREADS'(1) << lane_reg;
  assign pending_next = pending_reg & ~lane_onehot;

  vx_inter_lane_sel #(.N(NUM_THREADS), .LW(LANE_W)) u_sel_disp (
    .mask  (disp_tmask),
    .lane  (disp_lane),
    .found (disp_found)
  );

  vx_inter_lane_sel #(.N(NUM_THREADS), .LW(LANE_W)) u_sel_next (
    .mask  (pending_next),
    .lane  (next_lane),
    .found (next_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      disp_ready_reg   <= 1'b0;
      req_valid_reg    <= 1'b0;
      rsp_ready_reg    <= 1'b0;
      commit_valid_reg <= 1'b0;
      req_x_reg        <= '0;
      req_y_reg        <= '0;
      req_uuid_reg     <= '0;
      uuid_reg         <= '0;
      wid_reg          <= '0;
      tmask_reg        <= '0;
      pc_reg           <= '0;
      rd_reg           <= '0;
      wb_reg           <= 1'b0;
      pending_reg      <= '0;
      lane_reg         <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        x_reg[i]   <= '0;
        y_reg[i]   <= '0;
        res_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          disp_ready_reg <= 1'b1;
          if (disp_valid) begin
            disp_ready_reg <= 1'b0;
            uuid_reg       <= disp_uuid;
            wid_reg        <= disp_wid;
            tmask_reg      <= disp_tmask;
            pc_reg         <= disp_PC;
            rd_reg         <= disp_rd;
            wb_reg         <= disp_wb;
            pending_reg    <= disp_tmask;
            for (int i = 0; i < NUM_THREADS; i++) begin
              x_reg[i]   <= disp_x_lane[i];
              y_reg[i]   <= disp_y_lane[i];
              res_reg[i] <= '0;
            end
            if (disp_found) begin
              state_reg     <= ISSUE;
              lane_reg      <= disp_lane;
              req_valid_reg <= 1'b1;
              req_x_reg     <= disp_x_lane[disp_lane];
              req_y_reg     <= disp_y_lane[disp_lane];
              req_uuid_reg  <= disp_uuid;
            end else begin
              state_reg        <= COMMIT;
              commit_valid_reg <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (req_ready) begin
            state_reg     <= WAIT;
            req_valid_reg <= 1'b0;
            rsp_ready_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            res_reg[lane_reg] <= rsp_data;
            pending_reg       <= pending_next;
            rsp_ready_reg     <= 1'b0;
            if (next_found) begin
              state_reg     <= ISSUE;
              lane_reg      <= next_lane;
              req_valid_reg <= 1'b1;
              req_x_reg     <= x_reg[next_lane];
              req_y_reg     <= y_reg[next_lane];
            end else begin
              state_reg        <= COMMIT;
              commit_valid_reg <= 1'b1;
            end
          end
        end
        COMMIT: begin
          if (commit_ready) begin
            state_reg        <= IDLE;
            commit_valid_reg <= 1'b0;
            disp_ready_reg   <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign disp_ready   = disp_ready_reg;
  assign req_valid    = req_valid_reg;
  assign req_x        = req_x_reg;
  assign req_y        = req_y_reg;
  assign req_uuid     = req_uuid_reg;
  assign rsp_ready    = rsp_ready_reg;
  assign commit_valid = commit_valid_reg;
  assign commit_uuid  = uuid_reg;
  assign commit_wid   = wid_reg;
  assign commit_tmask = tmask_reg;
  assign commit_PC    = pc_reg;
  assign commit_rd    = rd_reg;
  assign commit_wb    = wb_reg;

endmodule

// File: tb/tb_vx_inter_agent.sv
// Scoreboard bench for vx_inter_agent with a zero/fixed-latency interpolator
// model computing 2*x + 3*y + 1.
module tb_vx_inter_agent;
  import vx_inter_pkg::*;

  localparam int NT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           disp_valid;
  logic           disp_ready;
  logic [43:0]    disp_uuid;
  logic [1:0]     disp_wid;
  logic [NT-1:0]  disp_tmask;
  logic [31:0]    disp_PC;
  logic [4:0]     disp_rd;
  logic           disp_wb;
  logic [NT*32-1:0] disp_x;
  logic [NT*32-1:0] disp_y;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_x;
  logic [31:0]    req_y;
  logic [43:0]    req_uuid;
  logic           rsp_valid;
  logic [31:0]    rsp_data;
  logic           rsp_ready;
  logic           commit_valid;
  logic           commit_ready;
  logic [43:0]    commit_uuid;
  logic [1:0]     commit_wid;
  logic [NT-1:0]  commit_tmask;
  logic [31:0]    commit_PC;
  logic [4:0]     commit_rd;
  logic           commit_wb;
  logic [NT*32-1:0] commit_data;

  vx_inter_agent #(
    .CORE_ID(0), .NUM_THREADS(NT), .NW_WIDTH(2), .UUID_WIDTH(44), .NR_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_uuid(disp_uuid), .disp_wid(disp_wid), .disp_tmask(disp_tmask),
    .disp_PC(disp_PC), .disp_rd(disp_rd), .disp_wb(disp_wb),
    .disp_x(disp_x), .disp_y(disp_y),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_uuid(req_uuid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_uuid(commit_uuid), .commit_wid(commit_wid), .commit_tmask(commit_tmask),
    .commit_PC(commit_PC), .commit_rd(commit_rd), .commit_wb(commit_wb),
    .commit_data(commit_data)
  );

  typedef struct {
    inter_meta_t      meta;
    logic [NT*32-1:0] data;
    int               lat;
  } exp_commit_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [43:0] uuid;
  } exp_req_t;

  exp_commit_t commit_q[$];
  exp_req_t    req_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_commit_cyc = -100;
  int req_pops = 0;
  bit req_seen = 0;
  bit commit_seen = 0;
  int exp_lat = -1;
  bit exp_b2b = 0;
  bit spur = 0;
  int rsp_delay = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] interp(input logic [31:0] x, input logic [31:0] y);
    return 32'd2 * x + 32'd3 * y + 32'd1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Interpolator model: one outstanding request, response after rsp_delay cycles.
  initial begin
    logic [31:0] data_h;
    int cnt;
    bit have;
    have = 0; cnt = 0; data_h = '0;
    rsp_valid = 1'b0; rsp_data = '0;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) have = 0;
      if (req_valid && req_ready) begin
        have = 1; cnt = rsp_delay; data_h = interp(req_x, req_y);
      end
      @(posedge clk); #2;
      if (reset) have = 0;
      rsp_valid = (have && cnt == 0) || spur;
      rsp_data  = (have && cnt == 0) ? data_h : 32'hDEAD_BEEF;
      if (have && cnt > 0) cnt--;
    end
  end

  // Monitor / scoreboard.
  initial begin
    inter_meta_t got_meta;
    exp_commit_t ec;
    exp_req_t    er;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (req_valid) begin
          if (req_q.size() == 0) chk("req_unexpected", 128'(req_valid), 128'(0));
          else begin
            chk("req_x", 128'(req_x), 128'(req_q[0].x));
            chk("req_y", 128'(req_y), 128'(req_q[0].y));
            chk("req_uuid", 128'(req_uuid), 128'(req_q[0].uuid));
            if (!req_seen) chk("req_latency", 128'(cyc - acc_cyc), 128'(1));
            req_seen = 1;
            if (req_ready) begin
              void'(req_q.pop_front());
              req_pops++;
            end
          end
        end
        if (commit_valid) begin
          if (commit_q.size() == 0) chk("commit_unexpected", 128'(commit_valid), 128'(0));
          else begin
            got_meta.uuid  = commit_uuid;
            got_meta.wid   = commit_wid;
            got_meta.tmask = commit_tmask;
            got_meta.pc    = commit_PC;
            got_meta.rd    = commit_rd;
            got_meta.wb    = commit_wb;
            chk("commit_meta", 128'(got_meta), 128'(commit_q[0].meta));
            chk("commit_data", commit_data, commit_q[0].data);
            if (!commit_seen) begin
              chk("req_all_issued", 128'(req_q.size()), 128'(0));
              if (commit_q[0].lat >= 0)
                chk("commit_latency", 128'(cyc - acc_cyc), 128'(commit_q[0].lat));
              commit_seen = 1;
            end
            if (commit_ready) begin
              void'(commit_q.pop_front());
              last_commit_cyc = cyc;
            end
          end
        end
        if (disp_valid && disp_ready) begin
          if (exp_b2b) chk("b2b_accept_gap", 128'(cyc - last_commit_cyc), 128'(1));
          ec.meta.uuid  = disp_uuid;
          ec.meta.wid   = disp_wid;
          ec.meta.tmask = disp_tmask;
          ec.meta.pc    = disp_PC;
          ec.meta.rd    = disp_rd;
          ec.meta.wb    = disp_wb;
          ec.data       = '0;
          ec.lat        = exp_lat;
          for (int i = 0; i < NT; i++) begin
            if (disp_tmask[i]) begin
              er.x    = disp_x[i*32 +: 32];
              er.y    = disp_y[i*32 +: 32];
              er.uuid = disp_uuid;
              req_q.push_back(er);
              ec.data[i*32 +: 32] = interp(er.x, er.y);
            end
          end
          commit_q.push_back(ec);
          acc_cyc = cyc; req_seen = 0; commit_seen = 0; req_pops = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [43:0] uuid, input logic [NT-1:0] tm,
                      input logic [NT*32-1:0] xv, input logic [NT*32-1:0] yv,
                      input int lat, input bit b2b);
    int n;
    disp_valid = 1'b1; disp_uuid = uuid; disp_wid = uuid[1:0]; disp_tmask = tm;
    disp_PC = 32'h1000 + uuid[31:0]; disp_rd = uuid[4:0]; disp_wb = uuid[0];
    disp_x = xv; disp_y = yv; exp_lat = lat; exp_b2b = b2b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!disp_ready && n < 300);
    if (!disp_ready) chk("disp_accept_timeout", 128'(disp_ready), 128'(1));
    step();
    exp_b2b = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((commit_q.size() != 0 || commit_valid) && n < 300);
    if (commit_q.size() != 0) chk("drain_timeout", 128'(commit_q.size()), 128'(0));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [NT*32-1:0] XV = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [NT*32-1:0] YV = {32'd3, 32'd2, 32'd1, 32'd0};

  initial begin
    int n;
    logic [NT-1:0]    tm;
    logic [NT*32-1:0] xr, yr;
    reset = 1'b1; disp_valid = 1'b0; disp_uuid = '0; disp_wid = '0; disp_tmask = '0;
    disp_PC = '0; disp_rd = '0; disp_wb = 1'b0; disp_x = '0; disp_y = '0;
    req_ready = 1'b1; commit_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_ctrl", 128'({disp_ready, req_valid, rsp_ready, commit_valid}), 128'(0));
    chk("rst_req", 128'({req_x, req_y, req_uuid}), 128'(0));
    chk("rst_commit_data", commit_data, 128'(0));
    chk("rst_commit_meta", 128'({commit_uuid, commit_wid, commit_tmask, commit_PC, commit_rd, commit_wb}), 128'(0));
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("disp_ready_after_rst", 128'(disp_ready), 128'(1));
    step();

    // Full warp, inactive-lane and empty-mask cases.
    send(44'h011, 4'b1111, XV, YV, 9, 0); disp_valid = 1'b0; wait_done();
    send(44'h022, 4'b1010, XV, YV, 5, 0); disp_valid = 1'b0; wait_done();
    send(44'h033, 4'b0000, XV, YV, 1, 0); disp_valid = 1'b0; wait_done();

    // Backpressure on every channel plus spurious response pulses.
    req_ready = 1'b0; commit_ready = 1'b0; rsp_delay = 3;
    send(44'h044, 4'b1111, XV, YV, -1, 0); disp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spur = (i == 1 || i == 2);
      step();
    end
    spur = 1'b0; req_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!commit_valid && n < 200);
    chk("stall_commit_seen", 128'(commit_valid), 128'(1));
    step();
    for (int i = 0; i < 4; i++) begin
      spur = (i == 0 || i == 2);
      step();
    end
    spur = 1'b0; commit_ready = 1'b1;
    wait_done();

    // Reset while waiting on lane 2.
    rsp_delay = 30;
    send(44'h055, 4'b1111, XV, YV, -1, 0); disp_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_pops == 3 && rsp_ready) && n < 200);
    chk("reach_wait_lane2", 128'({req_pops == 3, rsp_ready}), 128'(3));
    step();
    reset = 1'b1;
    commit_q.delete(); req_q.delete();
    step();
    @(negedge clk);
    chk("midrst_ctrl", 128'({disp_ready, req_valid, rsp_ready, commit_valid}), 128'(0));
    chk("midrst_req", 128'({req_x, req_y, req_uuid}), 128'(0));
    chk("midrst_commit_data", commit_data, 128'(0));
    chk("midrst_commit_meta", 128'({commit_uuid, commit_wid, commit_tmask, commit_PC, commit_rd, commit_wb}), 128'(0));
    step();
    reset = 1'b0; rsp_delay = 0;
    step();
    send(44'h066, 4'b1111, XV, YV, 9, 0); disp_valid = 1'b0; wait_done();

    // Back-to-back with disp_valid held high.
    send(44'h077, 4'b1111, XV, YV, 9, 0);
    send(44'h088, 4'b0110, YV, XV, 5, 1);
    disp_valid = 1'b0; wait_done();

    // Random masks and operands.
    for (int k = 0; k < 6; k++) begin
      tm = NT'($urandom_range(0, 15));
      for (int i = 0; i < NT; i++) begin
        xr[i*32 +: 32] = $urandom;
        yr[i*32 +: 32] = $urandom;
      end
      send(44'h100 + 44'(k), tm, xr, yr, 1 + 2 * $countones(tm), 0);
      disp_valid = 1'b0; wait_done();
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
